// File: rtl/snake_tick_ctrl.sv
// ============================================================================
// Module   : snake_tick_ctrl
// Purpose  : Game-speed scheduler for the snake core. Derives a 1 ms timebase
//            from sys_clk, issues one-cycle move_tick pulses at a
//            level-dependent period, sequences IDLE/RUN/PAUSE/OVER and raises
//            the level as food is eaten.
// Ports    : sys_clk     in   1  system clock
//            sys_rst_n   in   1  asynchronous active-low reset
//            start       in   1  pulse: new game (from IDLE or OVER)
//            pause       in   1  pulse: toggle RUN <-> PAUSE
//            game_over   in   1  pulse from collision logic
//            food_eaten  in   1  pulse from food logic
//            boost       in   1  level: speed-up request (boost build only)
//            move_tick   out  1  pulse: advance snake one cell
//            state       out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
//            level       out  4  current level, 0..LEVEL_MAX
//            period_ms   out 10  period currently being timed, in ms
// Config   : SNAKE_TICK_BOOST_EN - when defined, boost=1 in RUN advances the
//            ms counter by 2 per ms tick. When undefined, boost is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_tick_ctrl #(
  parameter int CLK_PER_MS     = 50_000,
  parameter int BASE_MS        = 500,
  parameter int STEP_MS        = 40,
  parameter int MIN_MS         = 100,
  parameter int LEVEL_MAX      = 9,
  parameter int FOOD_PER_LEVEL = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  input  logic       food_eaten,
  input  logic       boost,
  output logic       move_tick,
  output logic [1:0] state,
  output logic [3:0] level,
  output logic [9:0] period_ms
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int FW = (FOOD_PER_LEVEL > 1) ? $clog2(FOOD_PER_LEVEL) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  state_e          state_q,  state_d;
  logic [PW-1:0]   presc_q,  presc_d;
  logic [9:0]      ms_q,     ms_d;
  logic [3:0]      level_q,  level_d;
  logic [FW-1:0]   food_q,   food_d;
  logic [9:0]      period_q, period_d;
  logic            tick_q,   tick_d;

  logic            ms_tick;
  logic            ms_last;
  logic            boost_act;
  logic [10:0]     span_end;

  // Period for a given level, evaluated signed so a large level*STEP never
  // wraps around before the floor clamp is applied.
  function automatic logic [9:0] target_for(input logic [3:0] lvl);
    logic signed [10:0] t;
    t = $signed(11'(BASE_MS)) - ($signed({7'd0, lvl}) * $signed(11'(STEP_MS)));
    if (t < $signed(11'(MIN_MS))) begin
      return 10'(MIN_MS);
    end
    return t[9:0];
  endfunction

`ifdef SNAKE_TICK_BOOST_EN
  assign boost_act = boost;
`else
  logic unused_boost;
  assign unused_boost = boost;
  assign boost_act    = 1'b0;
`endif

  assign ms_tick  = (state_q == ST_RUN) && (presc_q == PW'(CLK_PER_MS - 1));

  // One ms tick covers ms_q (and ms_q+1 when boosted); the period ends once
  // that span reaches period-1, so an odd period is never counted past.
  assign span_end = {1'b0, ms_q} + (boost_act ? 11'd1 : 11'd0);
  assign ms_last  = ms_tick && (span_end >= ({1'b0, period_q} - 11'd1));

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    ms_d     = ms_q;
    level_d  = level_q;
    food_d   = food_q;
    period_d = period_q;
    tick_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d  = ST_RUN;
          presc_d  = '0;
          ms_d     = '0;
          level_d  = '0;
          food_d   = '0;
          period_d = target_for(4'd0);
        end
      end

      ST_RUN: begin
        presc_d = ms_tick ? '0 : presc_q + PW'(1);
        if (ms_tick) begin
          ms_d = ms_last ? 10'd0 : ms_q + (boost_act ? 10'd2 : 10'd1);
        end
        // New period is only picked up at a period boundary, never mid-flight.
        if (ms_last && !game_over) begin
          tick_d   = 1'b1;
          period_d = target_for(level_q);
        end
        if (food_eaten && !game_over) begin
          if (food_q == FW'(FOOD_PER_LEVEL - 1)) begin
            food_d = '0;
            if (level_q != 4'(LEVEL_MAX)) begin
              level_d = level_q + 4'd1;
            end
          end else begin
            food_d = food_q + FW'(1);
          end
        end
        if (game_over) begin
          state_d = ST_OVER;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (game_over) begin
          state_d = ST_OVER;
        end else if (pause) begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      ms_q     <= '0;
      level_q  <= '0;
      food_q   <= '0;
      period_q <= 10'(BASE_MS);
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      ms_q     <= ms_d;
      level_q  <= level_d;
      food_q   <= food_d;
      period_q <= period_d;
      tick_q   <= tick_d;
    end
  end

  assign move_tick = tick_q;
  assign state     = state_q;
  assign level     = level_q;
  assign period_ms = period_q;

endmodule

`default_nettype wire

// File: tb/tb_snake_tick_ctrl.sv
// ============================================================================
// Module   : tb_snake_tick_ctrl
// Purpose  : Self-checking bench for snake_tick_ctrl with small parameters
//            (CLK_PER_MS=4, BASE_MS=10, STEP_MS=3, MIN_MS=4, LEVEL_MAX=3,
//            FOOD_PER_LEVEL=2). A table of single-cycle FSM vectors is
//            followed by hand-written multi-cycle timing sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snake_tick_ctrl;

  localparam int CPM  = 4;
  localparam int BASE = 10;
  localparam int STEP = 3;
  localparam int MINM = 4;
  localparam int LMAX = 3;
  localparam int FPL  = 2;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, game_over = 1'b0;
  logic       food_eaten = 1'b0, boost = 1'b0;
  logic       move_tick;
  logic [1:0] state;
  logic [3:0] level;
  logic [9:0] period_ms;

  int n_checks = 0;
  int n_pass   = 0;

  snake_tick_ctrl #(
    .CLK_PER_MS     (CPM),
    .BASE_MS        (BASE),
    .STEP_MS        (STEP),
    .MIN_MS         (MINM),
    .LEVEL_MAX      (LMAX),
    .FOOD_PER_LEVEL (FPL)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .pause      (pause),
    .game_over  (game_over),
    .food_eaten (food_eaten),
    .boost      (boost),
    .move_tick  (move_tick),
    .state      (state),
    .level      (level),
    .period_ms  (period_ms)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       st;
    logic       pa;
    logic       go;
    logic       fd;
    logic [1:0] exp_state;
    logic [3:0] exp_level;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; pause = 0; game_over = 0; food_eaten = 0; boost = 0;
    sys_rst_n = 0;
    cyc();
    cyc();
    sys_rst_n = 1;
    cyc();
  endtask

  // Leaves the bench just after the edge that samples start (edge 0).
  task automatic start_game();
    start = 1;
    cyc();
    start = 0;
  endtask

  initial begin
    int tick_per;
    int exp_lvl[6];

    // state / level after each single-cycle vector, starting from IDLE
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd0}; // pause ignored in IDLE
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'd0}; // game_over ignored in IDLE
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0}; // food ignored in IDLE
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 4'd0}; // all three in IDLE -> RUN
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0}; // start ignored in RUN
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'd0}; // food 1 of 2
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'd1}; // food 2 of 2 -> level 1
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 4'd1}; // pause beats start
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'd1}; // food ignored in PAUSE
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 4'd1}; // start ignored in PAUSE
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 4'd1}; // resume
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 4'd1}; // game over, food ignored
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 4'd1}; // pause ignored in OVER
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 4'd1}; // game_over ignored in OVER
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0}; // restart clears level
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 4'd0}; // game_over beats pause

    // ---- Reset values and FSM vector table ----
    do_reset();
    chk("reset_state",  state,     0);
    chk("reset_level",  level,     0);
    chk("reset_period", period_ms, BASE);
    chk("reset_tick",   move_tick, 0);
    for (int i = 0; i < 16; i++) begin
      start = vecs[i].st; pause = vecs[i].pa;
      game_over = vecs[i].go; food_eaten = vecs[i].fd;
      cyc();
      start = 0; pause = 0; game_over = 0; food_eaten = 0;
      chk($sformatf("vec%0d_state", i),  state,     vecs[i].exp_state);
      chk($sformatf("vec%0d_level", i),  level,     vecs[i].exp_level);
      chk($sformatf("vec%0d_period", i), period_ms, BASE);
      chk($sformatf("vec%0d_tick", i),   move_tick, 0);
    end

    // ---- 1: start, ticks 40/80/120 edges after the start edge ----
    do_reset();
    start_game();
    chk("t1_state", state, 1);
    for (int k = 1; k <= 125; k++) begin
      cyc();
      chk($sformatf("t1_tick_e%0d", k), move_tick, (k % 40 == 0) ? 1 : 0);
    end

    // ---- 2: pause after 20 counting edges, hold 100, resume ----
    do_reset();
    start_game();
    repeat (19) cyc();
    pause = 1;
    cyc();
    pause = 0;
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("t2_hold_state_%0d", i), state, 2);
      chk($sformatf("t2_hold_tick_%0d", i), move_tick, 0);
      cyc();
    end
    pause = 1;
    cyc();
    pause = 0;
    chk("t2_resume_state", state, 1);
    for (int k = 1; k <= 25; k++) begin
      cyc();
      chk($sformatf("t2_tick_r%0d", k), move_tick, (k == 20) ? 1 : 0);
    end

    // ---- 3: level-up, deferred period load, saturation and clamp ----
    do_reset();
    start_game();
    cyc();
    food_eaten = 1;
    cyc();
    food_eaten = 0;
    chk("t3_level_after1", level, 0);
    food_eaten = 1;
    cyc();
    food_eaten = 0;
    chk("t3_level_after2", level, 1);
    chk("t3_period_held", period_ms, 10);
    for (int k = 4; k <= 40; k++) begin
      cyc();
      chk($sformatf("t3_tick_e%0d", k), move_tick, (k == 40) ? 1 : 0);
      chk($sformatf("t3_period_e%0d", k), period_ms, (k == 40) ? 7 : 10);
    end
    exp_lvl = '{1, 2, 2, 3, 3, 3};
    for (int j = 0; j < 6; j++) begin
      food_eaten = 1;
      cyc();
      chk($sformatf("t3_sat_level_%0d", j), level, exp_lvl[j]);
    end
    food_eaten = 0;
    for (int k = 47; k <= 84; k++) begin
      cyc();
      chk($sformatf("t3_tick2_e%0d", k), move_tick, (k == 68 || k == 84) ? 1 : 0);
      chk($sformatf("t3_period2_e%0d", k), period_ms, (k < 68) ? 7 : 4);
    end

    // ---- 4: game_over with food, restart clears, tick suppression ----
    do_reset();
    start_game();
    food_eaten = 1;
    cyc();
    food_eaten = 0;
    game_over = 1; food_eaten = 1;
    cyc();
    game_over = 0; food_eaten = 0;
    chk("t4_over_state", state, 3);
    chk("t4_over_level", level, 0);
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk($sformatf("t4_over_tick_%0d", i), move_tick, 0);
    end
    start_game();
    chk("t4_restart_state",  state,     1);
    chk("t4_restart_level",  level,     0);
    chk("t4_restart_period", period_ms, 10);
    food_eaten = 1;
    cyc();
    food_eaten = 0;
    chk("t4_food_cleared", level, 0);
    for (int k = 2; k <= 39; k++) begin
      cyc();
      chk($sformatf("t4_pre_tick_e%0d", k), move_tick, 0);
    end
    game_over = 1;
    cyc();
    game_over = 0;
    chk("t4_suppressed_tick", move_tick, 0);
    chk("t4_suppressed_state", state, 3);

    // ---- 5: asynchronous reset between edges while tick is high ----
    do_reset();
    start_game();
    food_eaten = 1;
    cyc();
    cyc();
    food_eaten = 0;
    repeat (38) cyc();
    chk("t5_pre_tick",   move_tick, 1);
    chk("t5_pre_period", period_ms, 7);
    chk("t5_pre_level",  level,     1);
    #2;
    sys_rst_n = 0;
    #1;
    chk("t5_rst_state",  state,     0);
    chk("t5_rst_level",  level,     0);
    chk("t5_rst_period", period_ms, BASE);
    chk("t5_rst_tick",   move_tick, 0);
    @(negedge sys_clk);
    sys_rst_n = 1;
    cyc();
    start = 1; pause = 1; game_over = 1;
    cyc();
    start = 0; pause = 0; game_over = 0;
    chk("t5_all_pulses_state", state, 1);
    for (int k = 1; k <= 40; k++) begin
      cyc();
      chk($sformatf("t5_tick_e%0d", k), move_tick, (k == 40) ? 1 : 0);
    end

    // ---- 6: boost held from start ----
`ifdef SNAKE_TICK_BOOST_EN
    tick_per = 20;
`else
    tick_per = 40;
`endif
    do_reset();
    boost = 1;
    start_game();
    for (int k = 1; k <= 82; k++) begin
      cyc();
      chk($sformatf("t6_tick_e%0d", k), move_tick, (k % tick_per == 0) ? 1 : 0);
    end
    chk("t6_period", period_ms, 10);
    boost = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
